// File: rtl/mux6_rr_arbiter_pkg.sv
// Shared definitions for the 6-requester round-robin mux scheduler:
// requester count, select width, FSM encodings and the pointer reset value.
package mux6_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 6;
  localparam int unsigned SEL_W = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Pointer starts at the last index so requester 0 wins the first scan.
  localparam logic [SEL_W-1:0] LAST_RST = 3'd5;

  // Select index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mux6_rr_arbiter_rr_pick6.sv
// Combinational round-robin pick: first requester at ptr+1, ptr+2, ... modulo 6.
// The scan ends on ptr itself, so a lone current holder is picked again.
module rr_pick6
  import mux6_rr_arbiter_pkg::*;
(
  input  logic [5:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] idx,
  output logic       found
);

  logic [7:0] req_ext;

  assign req_ext = {2'b00, req};

  // Scan six candidates in priority order, keeping the first hit.
  always_comb begin
    logic [3:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!found && cand < 4'd6 && req_ext[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin scheduler owning the select of a 6:1 single-bit mux.
// Each requester holds the mux for HOLD_CYCLES cycles or until it releases.
module mux6_rr_arbiter
  import mux6_rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] req,
  output logic [2:0] S,
  output logic [5:0] gnt,
  output logic       busy,
  output logic       slot_end
);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       last;
  logic [2:0]       pick_idx;
  logic             pick_found;
  logic [7:0]       req_ext;
  logic             terminate;

  assign req_ext = {2'b00, req};

  // During a slot last == S, so one pointer serves both the idle pick
  // and the back-to-back pick starting at S+1.
  rr_pick6 u_pick (
    .req   (req),
    .ptr   (last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Slot ends on expiry, release by the holder, or enable drop; all collapse to one pulse.
  always_comb begin
    terminate = 1'b0;
    if (state == GRANT) begin
      terminate = (cnt == '0) || !req_ext[S] || !en;
    end
  end

  assign slot_end = terminate;
  assign busy     = |gnt;

  // FSM, slot counter, round-robin pointer and registered mux controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= LAST_RST;
      S     <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state <= GRANT;
            S     <= pick_idx;
            gnt   <= sel2onehot(pick_idx);
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
            last  <= pick_idx;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          if (terminate) begin
            if (en && pick_found) begin
              S    <= pick_idx;
              gnt  <= sel2onehot(pick_idx);
              cnt  <= CNT_W'(HOLD_CYCLES - 1);
              last <= pick_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
